// File: rtl/spi_master_sequencer.sv
// Command/response sequencer for the SPI master control port: queues byte commands,
// issues them one at a time with the toXmit/ss/strobe handshake and queues tagged responses.
module spi_master_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       Clk_i,
    input  logic       Rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic [1:0] cmd_ss_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic [1:0] rsp_ss_o,
    output logic       rsp_err_o,
    output logic [7:0] m_toXmit_o,
    output logic [1:0] m_ss_o,
    output logic       m_strobe_o,
    input  logic [7:0] m_Rcvd_i,
    input  logic       m_Ready_i,
    input  logic       m_XmitFull_i,
    input  logic       m_busy_i,
    output logic       idle_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_PUSH} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ss;
        logic       err;
    } rsp_t;

    // Both queue ports use valid/ready: a beat moves on a clock edge where valid and
    // ready are both high; valid never depends on ready in this block.
    state_t          state;
    logic [7:0]      cmd_data_mem [DEPTH];
    logic [1:0]      cmd_ss_mem   [DEPTH];
    logic [AW-1:0]   cmd_wr_ptr;
    logic [AW-1:0]   cmd_rd_ptr;
    logic [CW-1:0]   cmd_cnt;
    logic [CW-1:0]   cmd_cnt_nxt;
    logic            cmd_ready_q;
    logic            cmd_push;
    logic            cmd_pop;

    rsp_t            rsp_mem [DEPTH];
    logic [AW-1:0]   rsp_wr_ptr;
    logic [AW-1:0]   rsp_rd_ptr;
    logic [CW-1:0]   rsp_cnt;
    logic            rsp_push;
    logic            rsp_pop;
    rsp_t            rsp_head;
    rsp_t            rsp_wr;

    logic [7:0]      tx_data_q;
    logic [1:0]      ss_q;
    logic            strobe_q;
    logic [7:0]      res_data_q;
    logic            res_err_q;
    logic [TW-1:0]   tmo_cnt;
    logic            ready_q;
    logic            issue;
    logic [1:0]      head_ss;

    function automatic logic is_onehot(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    assign head_ss  = cmd_ss_mem[cmd_rd_ptr];
    assign issue    = (state == ST_IDLE) && (cmd_cnt != '0) && (rsp_cnt < CW'(DEPTH))
                      && !m_busy_i && !m_XmitFull_i;
    assign cmd_push = cmd_valid_i && cmd_ready_q;
    assign cmd_pop  = issue;
    assign cmd_cnt_nxt = cmd_cnt + CW'(cmd_push) - CW'(cmd_pop);

    always_ff @(posedge Clk_i) begin
        if (cmd_push) begin
            cmd_data_mem[cmd_wr_ptr] <= cmd_data_i;
            cmd_ss_mem[cmd_wr_ptr]   <= cmd_ss_i;
        end
    end

    // Ready is registered from the next count, so a pop while full frees the slot a cycle later.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            cmd_wr_ptr  <= '0;
            cmd_rd_ptr  <= '0;
            cmd_cnt     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + AW'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + AW'(1);
            cmd_cnt     <= cmd_cnt_nxt;
            cmd_ready_q <= (cmd_cnt_nxt != CW'(DEPTH));
        end
    end

    assign rsp_push = (state == ST_PUSH);
    assign rsp_pop  = (rsp_cnt != '0) && rsp_ready_i;
    assign rsp_wr   = '{data: res_data_q, ss: ss_q, err: res_err_q};
    assign rsp_head = rsp_mem[rsp_rd_ptr];

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) rsp_mem[i] <= '0;
        end else begin
            if (rsp_push) begin
                rsp_mem[rsp_wr_ptr] <= rsp_wr;
                rsp_wr_ptr          <= rsp_wr_ptr + AW'(1);
            end
            if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + AW'(1);
            rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    // Timeout exits one count early because the PUSH cycle adds one more before the response shows.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state      <= ST_IDLE;
            tx_data_q  <= '0;
            ss_q       <= '0;
            strobe_q   <= 1'b0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            tmo_cnt    <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    strobe_q <= 1'b0;
                    if (issue) begin
                        tx_data_q <= cmd_data_mem[cmd_rd_ptr];
                        ss_q      <= head_ss;
                        if (is_onehot(head_ss)) begin
                            state <= ST_ISSUE;
                        end else begin
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                            state      <= ST_PUSH;
                        end
                    end
                end
                ST_ISSUE: begin
                    strobe_q <= 1'b1;
                    tmo_cnt  <= '0;
                    ready_q  <= m_Ready_i;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    strobe_q <= 1'b0;
                    ready_q  <= m_Ready_i;
                    tmo_cnt  <= tmo_cnt + TW'(1);
                    if (m_Ready_i && !ready_q) begin
                        res_data_q <= m_Rcvd_i;
                        res_err_q  <= 1'b0;
                        state      <= ST_PUSH;
                    end else if (tmo_cnt == TW'(TIMEOUT - 2)) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state      <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    strobe_q <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = (rsp_cnt != '0);
    assign rsp_data_o  = rsp_head.data;
    assign rsp_ss_o    = rsp_head.ss;
    assign rsp_err_o   = rsp_head.err;
    assign m_toXmit_o  = tx_data_q;
    assign m_ss_o      = ss_q;
    assign m_strobe_o  = strobe_q;
    assign idle_o      = (cmd_cnt == '0) && (rsp_cnt == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: a slave-side master model answers strobes with
// toXmit ^ 8'h99 and a transaction-level queue model predicts every response in order.
module tb_spi_master_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [1:0] cmd_ss = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_ss;
  logic       rsp_err;
  logic [7:0] m_to_xmit;
  logic [1:0] m_ss;
  logic       m_strobe;
  logic [7:0] m_rcvd = '0;
  logic       m_ready = 1'b0;
  logic       m_xfull = 1'b0;
  logic       m_busy;
  logic       busy_force = 1'b0;
  logic       mst_busy = 1'b0;
  logic       idle;
  assign m_busy = busy_force | mst_busy;

  spi_master_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clk_i(clk), .Rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data), .cmd_ss_i(cmd_ss),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_ss_o(rsp_ss), .rsp_err_o(rsp_err),
    .m_toXmit_o(m_to_xmit), .m_ss_o(m_ss), .m_strobe_o(m_strobe),
    .m_Rcvd_i(m_rcvd), .m_Ready_i(m_ready), .m_XmitFull_i(m_xfull), .m_busy_i(m_busy),
    .idle_o(idle)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic onehot(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  function automatic logic [7:0] slave_reply(input logic [7:0] x);
    return x ^ 8'h99;
  endfunction

  // Model: every accepted command owes exactly one response, in order.
  logic [10:0] exp_q[$];
  logic [9:0]  strb_q[$];
  bit          tmo_mode = 1'b0;
  bit          auto_pop = 1'b0;
  bit          rand_full = 1'b0;
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          strobe_cyc = 0;
  int          rsp_rise_cyc = 0;
  logic        prev_strobe = 1'b0;
  logic        prev_valid = 1'b0;
  logic [7:0]  last_x = '0;
  logic [1:0]  last_ss = '0;

  always @(negedge clk) begin
    logic        e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      strb_q.delete();
      prev_strobe = 1'b0;
      prev_valid  = 1'b0;
    end else begin
      check("idle", 32'(idle), 32'(exp_q.size() == 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        else check("rsp_head", 32'({rsp_data, rsp_ss, rsp_err}), 32'(exp_q[0]));
        if (!prev_valid) rsp_rise_cyc = cyc;
      end
      if (m_strobe) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        last_x  = m_to_xmit;
        last_ss = m_ss;
        if (prev_strobe) check("strobe_one_cycle", 32'(prev_strobe), 32'(0));
        if (strb_q.size() == 0) check("strobe_unexpected", 32'(m_strobe), 32'(0));
        else check("strobe_cmd", 32'({m_to_xmit, m_ss}), 32'(strb_q.pop_front()));
      end
      prev_strobe = m_strobe;
      prev_valid  = rsp_valid;
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cmd_valid && cmd_ready) begin
        e = !onehot(cmd_ss) || tmo_mode;
        exp_q.push_back({e ? 8'h00 : slave_reply(cmd_data), cmd_ss, e});
        if (onehot(cmd_ss)) strb_q.push_back({cmd_data, cmd_ss});
      end
    end
  end

  // SPI master model: busy during the transfer, then one Ready pulse with the reply.
  initial begin
    logic [7:0] x;
    forever begin
      @(negedge clk);
      if (rst_n && m_strobe && !tmo_mode && onehot(m_ss)) begin
        x = m_to_xmit;
        mst_busy = 1'b1;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        m_rcvd  = slave_reply(x);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready  = 1'b0;
        mst_busy = 1'b0;
        m_rcvd   = 8'($urandom);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (auto_pop) rsp_ready = 1'($urandom_range(0, 1));
    if (rand_full) m_xfull = ($urandom_range(0, 7) == 0);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] d, input logic [1:0] s);
    int k = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = d; cmd_ss = s;
    @(negedge clk);
    while (!cmd_ready && k < 3000) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(output logic [10:0] v);
    int k = 0;
    v = '0;
    @(negedge clk);
    while (!rsp_valid && k < 3000) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      check("rsp_wait_timeout", 32'(rsp_valid), 32'(1));
      return;
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    v = {rsp_data, rsp_ss, rsp_err};
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_data"},  32'(rsp_data), 32'(0));
    check({tag, "_rsp_ss"},    32'(rsp_ss), 32'(0));
    check({tag, "_rsp_err"},   32'(rsp_err), 32'(0));
    check({tag, "_toxmit"},    32'(m_to_xmit), 32'(0));
    check({tag, "_m_ss"},      32'(m_ss), 32'(0));
    check({tag, "_strobe"},    32'(m_strobe), 32'(0));
    check({tag, "_idle"},      32'(idle), 32'(1));
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] v;
    int          s0;
    int          k;
    int          pick;
    logic [1:0]  s;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single transfer
    s0 = strobe_cnt;
    push_cmd(8'hA5, 2'b01);
    pop_rsp(v);
    check("single_rsp", 32'(v), 32'({8'h3C, 2'b01, 1'b0}));
    check("single_strobes", 32'(strobe_cnt), 32'(s0 + 1));
    check("single_toxmit", 32'(last_x), 32'(8'hA5));
    check("single_ss", 32'(last_ss), 32'(2'b01));

    // Busy gating
    busy_force = 1'b1;
    s0 = strobe_cnt;
    push_cmd(8'h5E, 2'b10);
    wait_cycles(50);
    check("busy_no_strobe", 32'(strobe_cnt), 32'(s0));
    busy_force = 1'b0;
    k = 0;
    while (!m_strobe && k < 10) begin @(negedge clk); k++; end
    check("busy_release_within_2", 32'((k >= 1) && (k - 1 <= 2)), 32'(1));
    pop_rsp(v);
    check("busy_rsp", 32'(v), 32'({8'hC7, 2'b10, 1'b0}));

    // XmitFull gating
    m_xfull = 1'b1;
    s0 = strobe_cnt;
    push_cmd(8'h3A, 2'b01);
    wait_cycles(30);
    check("xfull_no_strobe", 32'(strobe_cnt), 32'(s0));
    m_xfull = 1'b0;
    pop_rsp(v);
    check("xfull_strobes", 32'(strobe_cnt), 32'(s0 + 1));

    // Back-pressure
    busy_force = 1'b1;
    push_cmd(8'h11, 2'b01);
    push_cmd(8'h22, 2'b10);
    push_cmd(8'h33, 2'b01);
    push_cmd(8'h44, 2'b10);
    cmd_valid = 1'b1; cmd_data = 8'h55; cmd_ss = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_cmd_full", 32'(cmd_ready), 32'(0));
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    s0 = strobe_cnt;
    busy_force = 1'b0;
    wait_cycles(300);
    check("bp_four_strobes", 32'(strobe_cnt), 32'(s0 + 4));
    check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
    push_cmd(8'h55, 2'b01);
    wait_cycles(100);
    check("bp_no_fifth", 32'(strobe_cnt), 32'(s0 + 4));
    pop_rsp(v);
    check("bp_first", 32'(v), 32'({8'h88, 2'b01, 1'b0}));
    k = 0;
    while (strobe_cnt != s0 + 5 && k < 100) begin wait_cycles(1); k++; end
    check("bp_fifth_issued", 32'(strobe_cnt), 32'(s0 + 5));
    pop_rsp(v);
    check("bp_second", 32'(v), 32'({8'hBB, 2'b10, 1'b0}));
    pop_rsp(v);
    pop_rsp(v);
    check("bp_fourth", 32'(v), 32'({8'hDD, 2'b10, 1'b0}));
    pop_rsp(v);
    check("bp_fifth", 32'(v), 32'({8'hCC, 2'b01, 1'b0}));

    // Timeout, then a normal transfer
    tmo_mode = 1'b1;
    push_cmd(8'h77, 2'b10);
    pop_rsp(v);
    check("tmo_rsp", 32'(v), 32'({8'h00, 2'b10, 1'b1}));
    check("tmo_latency", 32'(rsp_rise_cyc - strobe_cyc), 32'(TIMEOUT));
    tmo_mode = 1'b0;
    push_cmd(8'h0F, 2'b01);
    pop_rsp(v);
    check("post_tmo_rsp", 32'(v), 32'({8'h96, 2'b01, 1'b0}));

    // Illegal select followed by a legal one
    s0 = strobe_cnt;
    push_cmd(8'h42, 2'b11);
    push_cmd(8'h81, 2'b10);
    pop_rsp(v);
    check("illegal_rsp", 32'(v), 32'({8'h00, 2'b11, 1'b1}));
    pop_rsp(v);
    check("illegal_follow", 32'(v), 32'({8'h18, 2'b10, 1'b0}));
    check("illegal_strobes", 32'(strobe_cnt), 32'(s0 + 1));

    // Randomized traffic with random consumer and XmitFull
    auto_pop = 1'b1;
    rand_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      s = (pick == 0) ? 2'b11 : (pick == 1) ? 2'b00 : (pick < 6) ? 2'b01 : 2'b10;
      push_cmd(8'($urandom), s);
      wait_cycles($urandom_range(0, 3));
    end
    k = 0;
    while (exp_q.size() != 0 && k < 6000) begin wait_cycles(1); k++; end
    check("rand_drained", 32'(exp_q.size()), 32'(0));
    check("rand_idle", 32'(idle), 32'(1));
    auto_pop = 1'b0;
    rand_full = 1'b0;
    wait_cycles(1);
    rsp_ready = 1'b0;
    m_xfull = 1'b0;

    // Reset in the middle of a wait with commands queued
    tmo_mode = 1'b1;
    push_cmd(8'h01, 2'b01);
    push_cmd(8'h02, 2'b01);
    push_cmd(8'h03, 2'b10);
    wait_cycles(10);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midwait");
    @(posedge clk); #1 rst_n = 1'b1;
    tmo_mode = 1'b0;
    s0 = strobe_cnt;
    wait_cycles(20);
    check("midwait_no_rsp", 32'(rsp_valid), 32'(0));
    check("midwait_idle", 32'(idle), 32'(1));
    check("midwait_no_strobe", 32'(strobe_cnt), 32'(s0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
